// File: rtl/bullet_hit_detector.sv
// Bullet/enemy collision scanner. Once per frame it snapshots every bullet and
// enemy box, walks all pairs one per clock (enemy index inner), lets each
// bullet take at most one enemy and each enemy absorb at most one bullet, then
// reports both hit masks as a one-cycle pulse and bumps a saturating score.
module bullet_hit_detector #(
  parameter int BULLET_COUNT = 8,
  parameter int ENEMY_COUNT  = 4,
  parameter int BULLET_W     = 2,
  parameter int BULLET_H     = 8,
  parameter int ENEMY_W      = 32,
  parameter int ENEMY_H      = 32
) (
  input  logic                       clk25,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic [10*BULLET_COUNT-1:0] bullet_x_flat,
  input  logic [10*BULLET_COUNT-1:0] bullet_y_flat,
  input  logic [BULLET_COUNT-1:0]    bullet_active_flat,
  input  logic [10*ENEMY_COUNT-1:0]  enemy_x_flat,
  input  logic [10*ENEMY_COUNT-1:0]  enemy_y_flat,
  input  logic [ENEMY_COUNT-1:0]     enemy_alive_flat,
  output logic [BULLET_COUNT-1:0]    bullet_hit,
  output logic [ENEMY_COUNT-1:0]     enemy_hit,
  output logic                       hit_valid,
  output logic [15:0]                score,
  output logic                       busy
);

  localparam int BI_W = (BULLET_COUNT > 1) ? $clog2(BULLET_COUNT) : 1;
  localparam int EI_W = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
  localparam logic [BI_W-1:0] B_LAST = BI_W'(BULLET_COUNT - 1);
  localparam logic [EI_W-1:0] E_LAST = EI_W'(ENEMY_COUNT - 1);
  // Box extents widened to 11 bits so right/bottom edges near 1023 never wrap.
  localparam logic [10:0] BW = 11'(BULLET_W);
  localparam logic [10:0] BH = 11'(BULLET_H);
  localparam logic [10:0] EW = 11'(ENEMY_W);
  localparam logic [10:0] EH = 11'(ENEMY_H);

  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  state_t state_q, state_d;

  // Live inputs unpacked per slot
  logic [9:0] live_bx [BULLET_COUNT];
  logic [9:0] live_by [BULLET_COUNT];
  logic [9:0] live_ex [ENEMY_COUNT];
  logic [9:0] live_ey [ENEMY_COUNT];

  // Frame snapshot
  logic [9:0] snap_bx_q [BULLET_COUNT];
  logic [9:0] snap_by_q [BULLET_COUNT];
  logic [9:0] snap_ex_q [ENEMY_COUNT];
  logic [9:0] snap_ey_q [ENEMY_COUNT];
  logic [BULLET_COUNT-1:0] snap_ba_q;
  logic [ENEMY_COUNT-1:0]  snap_ea_q;
  logic                    snap_load;

  logic [BI_W-1:0]         b_q, b_d;
  logic [EI_W-1:0]         e_q, e_d;
  logic [BULLET_COUNT-1:0] bmask_q, bmask_d;
  logic [ENEMY_COUNT-1:0]  emask_q, emask_d;
  logic [BULLET_COUNT-1:0] bullet_hit_q, bullet_hit_d;
  logic [ENEMY_COUNT-1:0]  enemy_hit_q, enemy_hit_d;
  logic                    hit_valid_q, hit_valid_d;
  logic [15:0]             score_q, score_d;

  logic [10:0] cur_bx, cur_by, cur_ex, cur_ey;
  logic        overlap, pair_hit, last_pair;
  logic [16:0] score_sum;

  genvar gi;
  generate
    for (gi = 0; gi < BULLET_COUNT; gi++) begin : g_bullet_unpack
      assign live_bx[gi] = bullet_x_flat[gi*10 +: 10];
      assign live_by[gi] = bullet_y_flat[gi*10 +: 10];
    end
    for (gi = 0; gi < ENEMY_COUNT; gi++) begin : g_enemy_unpack
      assign live_ex[gi] = enemy_x_flat[gi*10 +: 10];
      assign live_ey[gi] = enemy_y_flat[gi*10 +: 10];
    end
  endgenerate

  // State register
  always_ff @(posedge clk25) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; ticks outside IDLE are simply dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_tick) state_d = SCAN;
      SCAN:    if (last_pair)  state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy      = (state_q != IDLE);
    snap_load = (state_q == IDLE) && frame_tick;
  end

  // Current pair test, read only from the snapshot
  always_comb begin
    cur_bx    = {1'b0, snap_bx_q[b_q]};
    cur_by    = {1'b0, snap_by_q[b_q]};
    cur_ex    = {1'b0, snap_ex_q[e_q]};
    cur_ey    = {1'b0, snap_ey_q[e_q]};
    overlap   = (cur_bx < cur_ex + EW) && (cur_bx + BW > cur_ex) &&
                (cur_by < cur_ey + EH) && (cur_by + BH > cur_ey);
    pair_hit  = snap_ba_q[b_q] && snap_ea_q[e_q] &&
                !bmask_q[b_q] && !emask_q[e_q] && overlap;
    last_pair = (b_q == B_LAST) && (e_q == E_LAST);
  end

  // Scan bookkeeping, report pulse and saturating score
  always_comb begin
    b_d          = b_q;
    e_d          = e_q;
    bmask_d      = bmask_q;
    emask_d      = emask_q;
    bullet_hit_d = '0;
    enemy_hit_d  = '0;
    hit_valid_d  = 1'b0;
    score_d      = score_q;
    score_sum    = {1'b0, score_q};
    for (int i = 0; i < ENEMY_COUNT; i++) score_sum = score_sum + 17'(emask_q[i]);
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          b_d     = '0;
          e_d     = '0;
          bmask_d = '0;
          emask_d = '0;
        end
      end
      SCAN: begin
        if (pair_hit) begin
          bmask_d[b_q] = 1'b1;
          emask_d[e_q] = 1'b1;
        end
        if (e_q == E_LAST) begin
          e_d = '0;
          if (b_q != B_LAST) b_d = b_q + 1'b1;
        end else begin
          e_d = e_q + 1'b1;
        end
      end
      REPORT: begin
        bullet_hit_d = bmask_q;
        enemy_hit_d  = emask_q;
        hit_valid_d  = 1'b1;
        score_d      = score_sum[16] ? 16'hFFFF : score_sum[15:0];
      end
      default: ;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk25) begin
    if (rst) begin
      b_q          <= '0;
      e_q          <= '0;
      bmask_q      <= '0;
      emask_q      <= '0;
      bullet_hit_q <= '0;
      enemy_hit_q  <= '0;
      hit_valid_q  <= 1'b0;
      score_q      <= '0;
    end else begin
      b_q          <= b_d;
      e_q          <= e_d;
      bmask_q      <= bmask_d;
      emask_q      <= emask_d;
      bullet_hit_q <= bullet_hit_d;
      enemy_hit_q  <= enemy_hit_d;
      hit_valid_q  <= hit_valid_d;
      score_q      <= score_d;
    end
  end

  // Snapshot capture on an accepted tick; contents are don't-care until then
  always_ff @(posedge clk25) begin
    if (snap_load) begin
      snap_bx_q <= live_bx;
      snap_by_q <= live_by;
      snap_ex_q <= live_ex;
      snap_ey_q <= live_ey;
      snap_ba_q <= bullet_active_flat;
      snap_ea_q <= enemy_alive_flat;
    end
  end

  assign bullet_hit = bullet_hit_q;
  assign enemy_hit  = enemy_hit_q;
  assign hit_valid  = hit_valid_q;
  assign score      = score_q;

endmodule

// File: doc/bullet_hit_detector.md
# bullet_hit_detector

Downstream of the bullet controller. Once per frame it snapshots all bullet positions and all enemy positions, then tests every bullet/enemy pair for rectangle overlap, one pair per clock. At the end of the scan it returns a one-cycle `bullet_hit` vector to the bullet controller and an `enemy_hit` vector to the enemy logic. It also keeps a saturating score.

## Interface
- `BULLET_COUNT`, default 8: number of bullet slots; matches the bullet controller.
- `ENEMY_COUNT`, default 4: number of enemy slots.
- `BULLET_W`, default 2: bullet box width in pixels.
- `BULLET_H`, default 8: bullet box height in pixels.
- `ENEMY_W`, default 32: enemy box width in pixels.
- `ENEMY_H`, default 32: enemy box height in pixels.
- `clk25`  in  1  25 MHz pixel clock; the only clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `frame_tick`  in  1  one-cycle scan request, normally at vsync start.
- `bullet_x_flat`  in  10*BULLET_COUNT  bullet top-left x; slot i is bits [i*10 +: 10].
- `bullet_y_flat`  in  10*BULLET_COUNT  bullet top-left y.
- `bullet_active_flat`  in  BULLET_COUNT  bullet slot valid.
- `enemy_x_flat`  in  10*ENEMY_COUNT  enemy top-left x.
- `enemy_y_flat`  in  10*ENEMY_COUNT  enemy top-left y.
- `enemy_alive_flat`  in  ENEMY_COUNT  enemy slot valid.
- `bullet_hit`  out  BULLET_COUNT  one-cycle pulse per bullet that hit an enemy.
- `enemy_hit`  out  ENEMY_COUNT  one-cycle pulse per enemy that was hit.
- `hit_valid`  out  1  high in the report cycle; asserted even when no hits occurred.
- `score`  out  16  running count of enemies hit; saturates at 16'hFFFF.
- `busy`  out  1  high while in SCAN or REPORT.

## Operation
- FSM states: IDLE, SCAN, REPORT.
- **IDLE**
  - On `frame_tick`, register all six position/valid input vectors into snapshot registers.
  - Clear the accumulating masks `bmask` (BULLET_COUNT bits) and `emask` (ENEMY_COUNT bits).
  - Set pair indices b=0, e=0 and go to SCAN.
- **SCAN**
  - Each cycle evaluates pair (b,e) from the snapshot only. Live inputs are ignored until the next tick.
  - Index order: e is the inner index, b the outer. e wraps to 0 and b increments when e==ENEMY_COUNT-1.
  - The scan takes N = BULLET_COUNT*ENEMY_COUNT cycles.
  - Overlap is true when all of these hold, using 11-bit unsigned arithmetic (no wrap):
    - bx < ex+ENEMY_W
    - bx+BULLET_W > ex
    - by < ey+ENEMY_H
    - by+BULLET_H > ey
  - A pair scores only if all of these hold: the bullet is active, the enemy is alive, `bmask[b]`==0, `emask[e]`==0, and the boxes overlap. Scoring sets both `bmask[b]` and `emask[e]`.
  - Consequences of the scoring rule:
    - One bullet kills at most one enemy: the lowest-index overlapping enemy not already taken.
    - One enemy absorbs at most one bullet: the lowest-index bullet.
    - A later bullet overlapping an already-taken enemy does not hit, and stays in flight.
  - After pair (BULLET_COUNT-1, ENEMY_COUNT-1), go to REPORT.
- **REPORT** (exactly one cycle)
  - Outputs are registered and held for this cycle only: `bullet_hit`=`bmask`, `enemy_hit`=`emask`, `hit_valid`=1.
  - `score` += popcount(`emask`), saturating at 16'hFFFF.
  - Return to IDLE.
- **Outside REPORT:** `bullet_hit`, `enemy_hit` and `hit_valid` are 0.
- **frame_tick while busy:** ignored, not queued.
- **Reset:** from any state, go to IDLE the next cycle. All outputs are 0 (`score`=0, `busy`=0) and masks are cleared. A scan interrupted by reset produces no report.

## Timing
- `frame_tick` sampled high in IDLE at edge T. Snapshot is taken at T, and SCAN occupies cycles T+1..T+N.
- REPORT is cycle T+N+1. `bullet_hit`, `enemy_hit` and `hit_valid` are visible after edge T+N+1, for one cycle. With defaults N=32, so the pulse follows the tick by 33 cycles.
- `score` updates at the same edge the pulses appear.
- `busy` rises at T+1 and falls after the REPORT cycle. The earliest next accepted tick is cycle T+N+2.
- Minimum tick spacing is N+2 cycles. A 25 MHz frame gives ample margin.
- The bullet controller clears slots on the `bullet_hit` pulse in the same cycle. Bullets keep moving during the scan, so hits reflect positions at the tick.

## Test plan
- **Single hit:** bullet0 at (100,100) active, enemy0 at (90,80) alive, tick → after 33 cycles `bullet_hit`=8'h01, `enemy_hit`=4'h1, `hit_valid`=1 for one cycle, `score`=1.
- **Edge miss:** bullet0 at (122,100), enemy0 at (90,80), so bx == ex+ENEMY_W → no hit, `hit_valid`=1 with both vectors 0, `score` unchanged.
- **Contention:** bullets 2 and 5 both overlap enemy1 → `bullet_hit`=8'h04, `enemy_hit`=4'h2. Bullet 5 overlapping enemy1 and enemy3, with bullet 2 overlapping only enemy1 → `bullet_hit`=8'h24, `enemy_hit`=4'hA.
- **Inactive/dead:** overlapping bullet with active=0, or enemy with alive=0 → no hit. A second tick at cycle 10 of a scan is ignored: exactly one `hit_valid` pulse.
- **Reset mid-scan:** assert `rst` at SCAN cycle 15 → no `hit_valid`, `busy`=0 the cycle after, `score`=0. A new tick then scans normally.
- **Saturation:** preload `score` to 16'hFFFE via 65534 single-hit frames (or force), then a frame with 3 enemy hits → `score`=16'hFFFF.
